// File: rtl/otter_crypto_pkg.sv
// Shared types and constants for the OTTER ENCRY sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package otter_crypto_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } crypto_state_t;

    localparam logic [31:0] CRYPTO_DELTA = 32'h9E3779B9;
    localparam int          CRYPTO_ROT   = 3;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/otter_crypto_round.sv
// One combinational ARX round; decrypt path built only with CRYPTO_DECRYPT_EN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is registered.
module otter_crypto_round (
    input  logic [31:0] x,
    input  logic [31:0] k_i,
    input  logic        mode,
    output logic [31:0] x_n
);
    import otter_crypto_pkg::*;

    logic [31:0] enc_t;
`ifdef CRYPTO_DECRYPT_EN
    logic [31:0] dec_t;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    always_comb begin
        enc_t = x ^ k_i;
        x_n   = ((enc_t << CRYPTO_ROT) | (enc_t >> (32 - CRYPTO_ROT))) + k_i;
`ifdef CRYPTO_DECRYPT_EN
        // Exact inverse of the encrypt round: undo the add, then the rotate, then the xor.
        dec_t = x - k_i;
        if (mode == MODE_DEC) begin
            x_n = ((dec_t >> CRYPTO_ROT) | (dec_t << (32 - CRYPTO_ROT))) ^ k_i;
        end
`endif
    end

endmodule

// File: rtl/otter_crypto_seq.sv
// Multi-round ENCRY sequencer (decrypt support under CRYPTO_DECRYPT_EN).
// Latency: NUM_ROUNDS+1 cycles from the start edge to the one-cycle CS_DONE.
// Backpressure: CS_START ignored while CS_BUSY; CS_ABORT cancels ROUND silently.
module otter_crypto_seq #(
    parameter int NUM_ROUNDS = 4
) (
    input  logic        CS_CLK,
    input  logic        CS_RESET,
    input  logic        CS_START,
    input  logic        CS_ABORT,
    input  logic        CS_MODE,
    input  logic [31:0] CS_DATA,
    input  logic [31:0] CS_KEY,
    output logic        CS_BUSY,
    output logic        CS_DONE,
    output logic [31:0] CS_RESULT
);
    import otter_crypto_pkg::*;

    localparam int             RW     = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
    localparam logic [RW-1:0]  R_LAST = RW'(NUM_ROUNDS - 1);

    crypto_state_t state_q, state_d;
    logic [31:0]   x_q, x_d, k_q, k_d, result_q, result_d;
    logic [RW-1:0] r_q, r_d;
    logic          mode_q, mode_d;
    logic [31:0]   idx, k_i, x_round;

`ifndef CRYPTO_DECRYPT_EN
    logic unused_cs_mode;
    assign unused_cs_mode = CS_MODE;
`endif

    // Decrypt walks the key schedule backwards so it undoes encrypt round by round.
    always_comb begin
        idx = 32'(r_q);
`ifdef CRYPTO_DECRYPT_EN
        if (mode_q == MODE_DEC) begin
            idx = 32'(NUM_ROUNDS - 1) - 32'(r_q);
        end
`endif
        k_i = k_q ^ (idx * CRYPTO_DELTA);
    end

    otter_crypto_round u_round (
        .x    (x_q),
        .k_i  (k_i),
        .mode (mode_q),
        .x_n  (x_round)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        k_d      = k_q;
        r_d      = r_q;
        mode_d   = mode_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (CS_START && !CS_ABORT) begin
                    state_d = ROUND;
                    x_d     = CS_DATA;
                    k_d     = CS_KEY;
                    r_d     = '0;
`ifdef CRYPTO_DECRYPT_EN
                    mode_d  = CS_MODE;
`else
                    mode_d  = MODE_ENC;
`endif
                end
            end
            ROUND: begin
                if (CS_ABORT) begin
                    state_d = IDLE;
                end else begin
                    x_d = x_round;
                    // Hold the counter on the last round so it never wraps.
                    if (r_q == R_LAST) begin
                        state_d  = DONE;
                        result_d = x_round;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CS_CLK or posedge CS_RESET) begin
        if (CS_RESET) begin
            state_q  <= IDLE;
            x_q      <= '0;
            k_q      <= '0;
            r_q      <= '0;
            mode_q   <= MODE_ENC;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            k_q      <= k_d;
            r_q      <= r_d;
            mode_q   <= mode_d;
            result_q <= result_d;
        end
    end

    assign CS_BUSY   = (state_q != IDLE);
    assign CS_DONE   = (state_q == DONE);
    assign CS_RESULT = result_q;

endmodule

// File: tb/tb_otter_crypto_seq.sv
// Self-checking bench for otter_crypto_seq (NUM_ROUNDS=4 and NUM_ROUNDS=1 instances).
module tb_otter_crypto_seq;

`ifdef CRYPTO_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start4, abort4, mode4, busy4, done4;
    logic [31:0] data4, key4, res4;
    logic        start1, abort1, mode1, busy1, done1;
    logic [31:0] data1, key1, res1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    otter_crypto_seq #(.NUM_ROUNDS(4)) u_dut4 (
        .CS_CLK(clk), .CS_RESET(rst), .CS_START(start4), .CS_ABORT(abort4),
        .CS_MODE(mode4), .CS_DATA(data4), .CS_KEY(key4),
        .CS_BUSY(busy4), .CS_DONE(done4), .CS_RESULT(res4)
    );

    otter_crypto_seq #(.NUM_ROUNDS(1)) u_dut1 (
        .CS_CLK(clk), .CS_RESET(rst), .CS_START(start1), .CS_ABORT(abort1),
        .CS_MODE(mode1), .CS_DATA(data1), .CS_KEY(key1),
        .CS_BUSY(busy1), .CS_DONE(done1), .CS_RESULT(res1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Whole-operation reference: loop over the key schedule with plain arithmetic.
    function automatic logic [31:0] model_crypt(input logic [31:0] d, input logic [31:0] k,
                                                input bit dec, input int n);
        logic [31:0] x, ki, t;
        x = d;
        if (!dec) begin
            for (int i = 0; i < n; i++) begin
                ki = k ^ (32'(i) * 32'h9E3779B9);
                t  = x ^ ki;
                x  = ((t << 3) | (t >> 29)) + ki;
            end
        end else begin
            for (int i = n - 1; i >= 0; i--) begin
                ki = k ^ (32'(i) * 32'h9E3779B9);
                t  = x - ki;
                x  = ((t >> 3) | (t << 29)) ^ ki;
            end
        end
        return x;
    endfunction

    // Timing model for the 4-round instance: a countdown of remaining round cycles.
    int          m_left    = 0;
    bit          m_done    = 1'b0;
    logic [31:0] m_result  = 32'h0;
    logic [31:0] m_pending = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left   = 0;
            m_done   = 1'b0;
            m_result = 32'h0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (abort4) begin
                m_left = 0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done   = 1'b1;
                    m_result = m_pending;
                end
            end
        end else if (start4 && !abort4) begin
            m_left    = 4;
            m_pending = model_crypt(data4, key4, DEC_EN && mode4, 4);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_busy", {31'b0, busy4}, {31'b0, (m_left > 0) || m_done});
            check("cmp_done", {31'b0, done4}, {31'b0, m_done});
            check("cmp_result", res4, m_result);
        end
    end

    task automatic wait_done4(input int bound, output int cyc);
        cyc = -1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (done4) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) check("done4_timeout", 32'h0, 32'h1);
    endtask

    // Issues one start, returns cycles from start edge to done cycle, ends back in IDLE.
    task automatic run4(input logic [31:0] d, input logic [31:0] k, input logic m, output int cyc);
        int c;
        data4  = d;
        key4   = k;
        mode4  = m;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("busy_after_start", {31'b0, busy4}, 32'h1);
        wait_done4(20, c);
        cyc = (c < 0) ? -1 : c + 1;
        @(negedge clk);
        check("done_one_cycle", {31'b0, done4}, 32'h0);
    endtask

    logic [31:0] enc_a, prev;
    int cyc;

    initial begin
        start4 = 0; abort4 = 0; mode4 = 0; data4 = 0; key4 = 0;
        start1 = 0; abort1 = 0; mode1 = 0; data1 = 0; key1 = 0;

        check("model_n1", model_crypt(32'h1, 32'h0, 1'b0, 1), 32'h00000008);
        check("model_n2", model_crypt(32'h0, 32'h0, 1'b0, 2), 32'h8FF34785);
        check("model_inverse",
              model_crypt(model_crypt(32'h12345678, 32'hDEADBEEF, 1'b0, 4), 32'hDEADBEEF, 1'b1, 4),
              32'h12345678);

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy4}, 32'h0);
        check("rst_done", {31'b0, done4}, 32'h0);
        check("rst_result", res4, 32'h0);
        check("rst_result1", res1, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        enc_a = model_crypt(32'h12345678, 32'hDEADBEEF, 1'b0, 4);
        run4(32'h12345678, 32'hDEADBEEF, 1'b0, cyc);
        check("latency_n4", cyc, 32'd5);
        check("enc_result", res4, enc_a);

        run4(enc_a, 32'hDEADBEEF, 1'b1, cyc);
        check("latency_dec", cyc, 32'd5);
        prev = DEC_EN ? 32'h12345678 : model_crypt(enc_a, 32'hDEADBEEF, 1'b0, 4);
        check("round_trip", res4, prev);

        // Abort sampled at edge 2 of the operation.
        data4 = 32'hAAAA5555; key4 = 32'h01020304; mode4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        abort4 = 1'b1;
        @(negedge clk);
        abort4 = 1'b0;
        check("abort_idle", {31'b0, busy4}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'b0, done4}, 32'h0);
        end
        check("abort_keeps_result", res4, prev);

        // Abort together with start in IDLE.
        start4 = 1'b1; abort4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; abort4 = 1'b0;
        check("abort_blocks_start", {31'b0, busy4}, 32'h0);
        @(negedge clk);

        // Second start while busy, with different data, must be ignored.
        data4 = 32'h11111111; key4 = 32'h0BADF00D; start4 = 1'b1;
        @(negedge clk);
        data4 = 32'h22222222;
        @(negedge clk);
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(20, cyc);
        check("busy_start_ignored", res4, model_crypt(32'h11111111, 32'h0BADF00D, 1'b0, 4));
        @(negedge clk);

        // Back-to-back: start held high, next op begins in the IDLE cycle after DONE.
        data4 = 32'h0F0F0F0F; key4 = 32'h00012345; start4 = 1'b1;
        repeat (12) @(negedge clk);
        start4 = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_result", res4, model_crypt(32'h0F0F0F0F, 32'h00012345, 1'b0, 4));

        // Asynchronous reset in the middle of ROUND.
        data4 = 32'hCAFEBABE; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy4}, 32'h0);
        check("arst_done", {31'b0, done4}, 32'h0);
        check("arst_result", res4, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (7) begin
            @(negedge clk);
            check("arst_no_done", {31'b0, done4}, 32'h0);
        end

        // Single-round instance.
        data1 = 32'h00000001; key1 = 32'h0; mode1 = 1'b0; start1 = 1'b1;
        cyc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start1 = 1'b0;
                check("n1_busy", {31'b0, busy1}, 32'h1);
            end
            if (done1) begin
                cyc = c;
                break;
            end
        end
        check("n1_latency", cyc, 32'd2);
        check("n1_result", res1, 32'h00000008);
        @(negedge clk);
        check("n1_done_drop", {31'b0, done1}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/otter_crypto_seq.md
# otter_crypto_seq

Multi-cycle sequencer for the OTTER ENCRY instruction. It latches a 32-bit operand and key from the control unit and steps a one-round ARX datapath for NUM_ROUNDS cycles. It then returns the result with a one-cycle done pulse. The control FSM holds in EXECUTE while `CS_BUSY` is high and writes back on `CS_DONE`. The block replaces the fixed 4-cycle crypto count in the control FSM.

## Interface
Parameters:
- `NUM_ROUNDS`, default 4: rounds per operation, legal range 1..256.

Ports:
- `CS_CLK` input, 1: the single clock. All state updates happen on its rising edge.
- `CS_RESET` input, 1: asynchronous, active-high reset.
- `CS_START` input, 1: operation request. Sampled only in IDLE.
- `CS_ABORT` input, 1: cancels an in-flight operation. Driven from the interrupt-taken path.
- `CS_MODE` input, 1: 0 = encrypt, 1 = decrypt. Only honoured when `CRYPTO_DECRYPT_EN` is defined.
- `CS_DATA` input, 32: plaintext or ciphertext (rs1).
- `CS_KEY` input, 32: base key (rs2).
- `CS_BUSY` output, 1: high in every state except IDLE.
- `CS_DONE` output, 1: high for exactly one cycle, in state DONE.
- `CS_RESULT` output, 32: result register.

## Operation
- States are IDLE, ROUND and DONE.
- IDLE → ROUND:
  - Taken when `CS_START`=1 and `CS_ABORT`=0.
  - On that edge, latch `x`←`CS_DATA`, `k`←`CS_KEY` and `mode`←`CS_MODE`, and set round counter `r`←0.
- ROUND:
  - Each cycle, `x`←round(`x`, k_i) and `r`←`r`+1.
  - After the edge that applies round index NUM_ROUNDS-1, go to DONE. On that same edge, `CS_RESULT`←the final `x`.
- DONE → IDLE: unconditional.
- Round key: k_i = `k` ^ (i × 32'h9E3779B9), truncated to 32 bits. i is zero-extended to 32 bits.
- Encrypt round: x' = rotl(x ^ k_i, 3) + k_i mod 2^32, with i = r.
- Decrypt round: x' = rotr(x − k_i mod 2^32, 3) ^ k_i, with i = NUM_ROUNDS−1−r.
- Round counter width is max(1, $clog2(NUM_ROUNDS)). It never wraps within an operation.
- `CS_START` while BUSY is ignored; it is neither queued nor an error.
- `CS_ABORT` in ROUND:
  - Next state is IDLE.
  - No `CS_DONE`.
  - `CS_RESULT` keeps its previous value.
- `CS_ABORT` in IDLE blocks a same-cycle start.
- `CS_ABORT` in DONE is ignored; the completion stands.
- Operand inputs may change freely after the start edge.

## Timing
- Reset values:
  - state IDLE.
  - `CS_BUSY`=0, `CS_DONE`=0, `CS_RESULT`=32'h0.
  - `r`=0, `x`=0, `k`=0.
- Reset is asynchronous and takes effect mid-operation with no done pulse.
- Latency: with `CS_START` sampled at edge 0, the cycles between edges 0 and NUM_ROUNDS are ROUND. DONE (with `CS_RESULT` valid) is the cycle after edge NUM_ROUNDS.
  - This gives NUM_ROUNDS+1 cycles from start to done.
- `CS_BUSY` is high from the cycle after the start edge through the DONE cycle.
- Back-to-back: the earliest next start is sampled in the IDLE cycle after DONE.
- `CS_RESULT` stays stable from DONE until the next completed operation.
- All outputs are registered or decoded from state only. There are no combinational input-to-output paths.

## Configuration
- Macro: `CRYPTO_DECRYPT_EN`.
- Defined: `CS_MODE` is latched and the decrypt round plus reverse key order are built.
- Undefined: `CS_MODE` is ignored, `mode` is tied to encrypt and the decrypt datapath is absent.
  - Decrypt requests produce encrypt results.

## Structure
- Package `otter_crypto_pkg` holds:
  - the state enum `crypto_state_t` (IDLE, ROUND, DONE);
  - `CRYPTO_DELTA` = 32'h9E3779B9;
  - `CRYPTO_ROT` = 3;
  - the mode encodings.
- Sub-module `otter_crypto_round`:
  - purely combinational single round;
  - inputs x, k_i, mode; output x';
  - the decrypt path sits under the same macro.
- The top level holds the FSM, counter, key-index mux and registers.

## Test plan
- Reset and latency, NUM_ROUNDS=4, start at edge 0:
  - `CS_BUSY` rises after edge 0.
  - `CS_DONE`=1 exactly in the cycle after edge 4, then 0.
  - Async reset asserted mid-ROUND clears all outputs immediately.
- Single-round vector, NUM_ROUNDS=1, encrypt: `CS_DATA`=32'h00000001, `CS_KEY`=0 → `CS_RESULT`=32'h00000008.
- Round trip, NUM_ROUNDS=4, with `CRYPTO_DECRYPT_EN`:
  - Encrypt 32'h12345678 under key 32'hDEADBEEF, then decrypt the result with the same key → 32'h12345678.
  - Without the macro, the decrypt request equals the encrypt result.
- Abort at edge 2 of a 4-round operation:
  - State returns to IDLE with no `CS_DONE`.
  - `CS_RESULT` keeps its prior value.
  - Abort together with start in IDLE → no operation begins.
- Start while busy: a second `CS_START` during ROUND with different data is ignored; the result matches the first operand only.
